// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge-filter frame-scan sequencer.
package edge_pkg;

  typedef logic [15:0] pix565_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LINE  = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    FIN   = 3'd4
  } scan_state_t;

  localparam pix565_t BORDER_COLOR = 16'h0000;

  // Width able to index n items; never below one bit so degenerate sizes stay legal.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_scan_ctrl_if.sv
// Host, pixel-memory, filter and output-buffer signals of the scan sequencer.
interface edge_scan_ctrl_if
  import edge_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int LINE_W = 9
);
  logic              start;
  logic              pause;
  logic              busy;
  logic              done;
  logic [LINE_W-1:0] cur_line;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  pix565_t           rd_data;
  pix565_t           filt_in;
  pix565_t           filt_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  pix565_t           wr_data;

  modport master (
    input  start, pause, rd_data, filt_out,
    output busy, done, cur_line, rd_en, rd_addr, filt_in, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, pause, rd_data, filt_out,
    input  busy, done, cur_line, rd_en, rd_addr, filt_in, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/edge_tag_pipe.sv
// Fixed-depth delay line carrying {valid, border, addr} alongside pixels in flight.
module edge_tag_pipe #(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_border,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic              out_border,
  output logic [ADDR_W-1:0] out_addr
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic              valid_reg;
      logic              border_reg;
      logic [ADDR_W-1:0] addr_reg;

      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) begin
            valid_reg  <= 1'b0;
            border_reg <= 1'b0;
            addr_reg   <= '0;
          end else begin
            valid_reg  <= in_valid;
            border_reg <= in_border;
            addr_reg   <= in_addr;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (reset) begin
            valid_reg  <= 1'b0;
            border_reg <= 1'b0;
            addr_reg   <= '0;
          end else begin
            valid_reg  <= g_stage[gi-1].valid_reg;
            border_reg <= g_stage[gi-1].border_reg;
            addr_reg   <= g_stage[gi-1].addr_reg;
          end
        end
      end
    end
  endgenerate

  assign out_valid  = g_stage[DEPTH-1].valid_reg;
  assign out_border = g_stage[DEPTH-1].border_reg;
  assign out_addr   = g_stage[DEPTH-1].addr_reg;

endmodule

// File: rtl/edge_scan_ctrl.sv
// Frame-scan sequencer: reads pixels line by line, feeds the edge filter and
// writes latency-aligned results with the two leftmost columns forced black.
module edge_scan_ctrl
  import edge_pkg::*;
#(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 1,
  parameter int FILT_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  edge_scan_ctrl_if.master  bus
);

  localparam int L      = RD_LAT + FILT_LAT;
  localparam int X_W    = addr_width(H_RES);
  localparam int LINE_W = addr_width(V_RES);
  localparam int DRN_W  = addr_width(L);

  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
  localparam logic [LINE_W-1:0] Y_LAST    = LINE_W'(V_RES - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(L - 1);
  localparam logic [X_W-1:0]    BORDER_W  = X_W'(2);

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_LINE  = 3'(LINE);
  localparam logic [2:0] S_DRAIN = 3'(DRAIN);
  localparam logic [2:0] S_HOLD  = 3'(HOLD);
  localparam logic [2:0] S_FIN   = 3'(FIN);

  logic [2:0]        state_reg,    state_next;
  logic [X_W-1:0]    x_reg,        x_next;
  logic [LINE_W-1:0] line_reg,     line_next;
  logic [ADDR_W-1:0] lin_addr_reg, lin_addr_next;
  logic [DRN_W-1:0]  drn_reg,      drn_next;

  logic              tag_valid;
  logic              tag_border;
  logic [ADDR_W-1:0] tag_addr;
  logic              rd_issue;

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    line_next     = line_reg;
    lin_addr_next = lin_addr_reg;
    drn_next      = drn_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next    = S_LINE;
          x_next        = '0;
          line_next     = '0;
          lin_addr_next = '0;
        end
      end
      S_LINE: begin
        // Linear address simply keeps counting across lines.
        lin_addr_next = lin_addr_reg + 1'b1;
        x_next        = x_reg + 1'b1;
        if (x_reg == X_LAST) begin
          state_next = S_DRAIN;
          drn_next   = '0;
        end
      end
      S_DRAIN: begin
        drn_next = drn_reg + 1'b1;
        if (drn_reg == DRN_LAST) begin
          if (line_reg == Y_LAST) begin
            state_next = S_FIN;
          end else if (bus.pause) begin
            state_next = S_HOLD;
          end else begin
            state_next = S_LINE;
            x_next     = '0;
            line_next  = line_reg + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!bus.pause) begin
          state_next = S_LINE;
          x_next     = '0;
          line_next  = line_reg + 1'b1;
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      x_reg        <= '0;
      line_reg     <= '0;
      lin_addr_reg <= '0;
      drn_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      line_reg     <= line_next;
      lin_addr_reg <= lin_addr_next;
      drn_reg      <= drn_next;
    end
  end

  assign rd_issue = (state_reg == S_LINE);

  // Tags travel L cycles so the write lands exactly when the filter result does.
  edge_tag_pipe #(
    .DEPTH  (L),
    .ADDR_W (ADDR_W)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (rd_issue),
    .in_border  (x_reg < BORDER_W),
    .in_addr    (lin_addr_reg),
    .out_valid  (tag_valid),
    .out_border (tag_border),
    .out_addr   (tag_addr)
  );

  assign bus.rd_en    = rd_issue;
  assign bus.rd_addr  = lin_addr_reg;
  assign bus.filt_in  = bus.rd_data;
  assign bus.busy     = (state_reg == S_LINE) || (state_reg == S_DRAIN) || (state_reg == S_HOLD);
  assign bus.done     = (state_reg == S_FIN);
  assign bus.cur_line = line_reg;

  // Border masking also hides the stale filter history carried over from the previous line.
  assign bus.wr_en   = tag_valid;
  assign bus.wr_addr = tag_addr;
  assign bus.wr_data = (tag_valid && !tag_border) ? bus.filt_out : BORDER_COLOR;

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Directed bench for edge_scan_ctrl on an 8x2 frame with memory and filter models.
module tb_edge_scan_ctrl;

  logic clk;
  logic reset;

  edge_scan_ctrl_if #(.ADDR_W(4), .LINE_W(1)) bus ();

  edge_scan_ctrl #(
    .H_RES    (8),
    .V_RES    (2),
    .ADDR_W   (4),
    .RD_LAT   (1),
    .FILT_LAT (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel memory: one-cycle registered read, data = 0x0100 + address.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= 16'h0100 + 16'(bus.rd_addr);
  end

  // Weighted 3-tap filter model, two-cycle latency.
  logic [15:0] h0, h1, h2, fo;
  always @(posedge clk) begin
    h0 <= bus.filt_in;
    h1 <= h0;
    h2 <= h1;
    fo <= 16'(h0 + 16'd3 * h1 + 16'd5 * h2 + 16'h1000);
  end
  assign bus.filt_out = fo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_rd, exp_wr, wr_cnt, done_cnt, done_cyc;
  int rd_cyc [16];
  int wr_seen [16];

  function automatic logic [15:0] exp_pix(input int a);
    logic [15:0] d0, d1, d2;
    if ((a % 8) < 2) return 16'h0000;
    d0 = 16'h0100 + 16'(a);
    d1 = 16'h0100 + 16'(a - 1);
    d2 = 16'h0100 + 16'(a - 2);
    return 16'(d0 + 16'd3 * d1 + 16'd5 * d2 + 16'h1000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    exp_rd = 0; exp_wr = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -100;
    for (int i = 0; i < 16; i++) begin
      rd_cyc[i]  = -100;
      wr_seen[i] = 0;
    end
  endtask

  task automatic tick();
    int a;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rd_en) begin
      chk("rd_addr", bus.rd_addr, exp_rd % 16);
      chk("cur_line", bus.cur_line, (exp_rd % 16) / 8);
      rd_cyc[bus.rd_addr] = cyc;
      exp_rd++;
    end
    if (bus.wr_en) begin
      a = int'(bus.wr_addr);
      chk("wr_addr", bus.wr_addr, exp_wr % 16);
      chk("wr_latency", cyc - rd_cyc[a], 3);
      chk("wr_data", bus.wr_data, exp_pix(a));
      $display("write addr=%0d data=%04h cycle=%0d", a, bus.wr_data, cyc);
      wr_seen[a]++;
      wr_cnt++;
      exp_wr++;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic start_frame();
    clear_sb();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic finish_frame(input int gap);
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    chk("busy_at_done", bus.busy, 0);
    repeat (4) tick();
    chk("idle_rd_en", bus.rd_en, 0);
    chk("write_count", wr_cnt, 16);
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_cyc - rd_cyc[15], 4);
    chk("line_gap", rd_cyc[8] - rd_cyc[7], gap);
    for (int i = 0; i < 16; i++) chk("addr_written_once", wr_seen[i], 1);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    clear_sb();
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_cur_line", bus.cur_line, 0);
    reset = 1'b0;
    tick();

    // Plain frame.
    start_frame();
    finish_frame(4);

    // Pause held through line 0: park in HOLD for ten cycles.
    bus.pause = 1'b1;
    start_frame();
    for (int i = 0; i < 40 && exp_rd < 8; i++) tick();
    repeat (3) begin
      tick();
      chk("drain_rd_en", bus.rd_en, 0);
    end
    repeat (10) begin
      tick();
      chk("hold_rd_en", bus.rd_en, 0);
      chk("hold_wr_en", bus.wr_en, 0);
      chk("hold_busy", bus.busy, 1);
    end
    bus.pause = 1'b0;
    tick();
    chk("resume_rd_en", bus.rd_en, 1);
    chk("resume_rd_addr", bus.rd_addr, 8);
    finish_frame(14);

    // Start while busy is ignored.
    start_frame();
    repeat (3) tick();
    bus.start = 1'b1;
    repeat (2) begin
      tick();
      chk("busy_start_ignored", bus.busy, 1);
    end
    bus.start = 1'b0;
    finish_frame(4);

    // Reset while reading address 4, then a clean rescan.
    start_frame();
    for (int i = 0; i < 20 && !(bus.rd_en && bus.rd_addr == 4'd4); i++) tick();
    chk("abort_point", bus.rd_addr, 4);
    reset = 1'b1;
    tick();
    chk("abort_wr_en", bus.wr_en, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_done", bus.done, 0);
    tick();
    chk("abort_wr_en_hold", bus.wr_en, 0);
    reset = 1'b0;
    tick();
    chk("abort_wr_en_after", bus.wr_en, 0);
    start_frame();
    chk("rescan_rd_addr", bus.rd_addr, 0);
    finish_frame(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
